// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 lines, deframes
// 11-bit frames and queues good scan codes in a show-ahead FIFO with error pulses.
module ps2_kbd_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 20000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk_p,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_rd,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overflow,
   output logic       busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]            clk_sync_q, data_sync_q;
   logic [FILTER_LEN-1:0] filt_q;
   logic                  fclk_q, fclk_d;
   logic                  fall, data_bit;

   state_t                state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            shift_q, shift_d;
   logic                  par_ok_q, par_ok_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  frame_err_q, frame_err_d;
   logic                  parity_err_q, parity_err_d;
   logic                  overflow_q, overflow_d;
   logic                  push;

   logic [7:0]            mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic                  empty, full, pop, push_ok;

   // Lines idle high, so resetting the sync/filter chain to ones prevents a fake edge.
   always_ff @(posedge clk_p) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= '1;
         fclk_q      <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
         fclk_q      <= fclk_d;
      end
   end

   always_comb begin
      fclk_d = fclk_q;
      if (&filt_q) begin
         fclk_d = 1'b1;
      end else if (~|filt_q) begin
         fclk_d = 1'b0;
      end
   end

   assign fall     = fclk_q & ~fclk_d;
   assign data_bit = data_sync_q[1];

   always_ff @(posedge clk_p) begin
      if (reset) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_ok_q     <= 1'b0;
         tmo_q        <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_ok_q     <= par_ok_d;
         tmo_q        <= tmo_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overflow_q   <= overflow_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_ok_d     = par_ok_q;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      push         = 1'b0;
      tmo_d        = (state_q == S_IDLE || fall) ? '0 : tmo_q + TW'(1);

      case (state_q)
         S_IDLE: begin
            if (fall && !data_bit) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d   = {data_bit, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_ok_d = (^shift_q) ^ data_bit;
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               if (!data_bit) begin
                  frame_err_d = 1'b1;
               end else if (par_ok_q) begin
                  push = 1'b1;
               end else begin
                  parity_err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line stalled mid-frame: drop the partial byte and report it as a framing error.
      if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
         state_d     = S_IDLE;
         frame_err_d = 1'b1;
         tmo_d       = '0;
      end
   end

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = rx_rd & ~empty;
   assign push_ok    = push & (~full | pop);
   assign overflow_d = push & full & ~pop;

   always_ff @(posedge clk_p) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_p) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
      end
   end

   assign rx_valid   = ~empty;
   assign rx_data    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: drives jittered PS/2 frames and checks against a queue-based
// model of the frame rules and the 8-entry scan-code FIFO.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 1000;
   localparam int DEPTH      = 8;
   localparam int HALF       = 80;

   logic       clk_p = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_rd = 1'b0;
   logic       frame_err, parity_err, overflow, busy;

   int checks = 0;
   int failures = 0;
   int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, long_cnt = 0;
   logic fe_prev = 1'b0, pe_prev = 1'b0, ov_prev = 1'b0;
   logic [7:0] exp_q[$];

   ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
      .clk_p(clk_p), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
      .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow), .busy(busy)
   );

   always #5 clk_p = ~clk_p;

   // Pulse counters; a pulse seen on two consecutive cycles counts as too long.
   always @(negedge clk_p) begin
      if (frame_err)  fe_cnt <= fe_cnt + 1;
      if (parity_err) pe_cnt <= pe_cnt + 1;
      if (overflow)   ov_cnt <= ov_cnt + 1;
      if ((frame_err && fe_prev) || (parity_err && pe_prev) || (overflow && ov_prev))
         long_cnt <= long_cnt + 1;
      fe_prev <= frame_err;
      pe_prev <= parity_err;
      ov_prev <= overflow;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 5 ms");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk_p);
      #1;
   endtask

   // Drives nbits of a frame; optional 3-cycle clock glitch before bit glitch_bit,
   // optional rx_rd pulse aligned with the edge on which the stop bit is consumed.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int nbits, input int glitch_bit, input bit rd_on_stop);
      logic [10:0] bits;
      int h;
      bits = {stop, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         h = $urandom_range(HALF - 10, HALF + 10);
         ps2_data = bits[i];
         wait_clk(h / 2);
         if (i == glitch_bit) begin
            ps2_clk = 1'b0;
            wait_clk(3);
            ps2_clk = 1'b1;
            wait_clk(20);
         end
         ps2_clk = 1'b0;
         if (rd_on_stop && i == 10) begin
            wait_clk(2 + FILTER_LEN);
            rx_rd = 1'b1;
            wait_clk(1);
            rx_rd = 1'b0;
            wait_clk(h - 3 - FILTER_LEN);
         end else begin
            wait_clk(h);
         end
         ps2_clk = 1'b1;
         wait_clk(h / 2);
      end
      ps2_data = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int glitch_bit, input bit rd_on_stop,
                            output int dfe, output int dpe, output int dov);
      int f0, p0, o0;
      f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
      send_frame(d, par, stop, 11, glitch_bit, rd_on_stop);
      wait_clk(20);
      dfe = fe_cnt - f0;
      dpe = pe_cnt - p0;
      dov = ov_cnt - o0;
      $display("frame d=%02h par=%0d stop=%0d -> frame_err=%0d parity_err=%0d overflow=%0d valid=%0d",
               d, par, stop, dfe, dpe, dov, rx_valid);
   endtask

   // Behavioural frame rules: stop bit first, then odd parity, then FIFO capacity.
   task automatic model_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit pop_same, output int efe, output int epe, output int eov);
      efe = 0; epe = 0; eov = 0;
      if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
      if (stop == 1'b0) efe = 1;
      else if (((^d) ^ par) != 1'b1) epe = 1;
      else if (exp_q.size() >= DEPTH) eov = 1;
      else exp_q.push_back(d);
   endtask

   task automatic drain(input string tag);
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rx_valid !== 1'b1 || rx_data !== e) begin
            failures++;
            $display("FAIL %s_pop: got valid=%0b data=%02h, required valid=1 data=%02h", tag, rx_valid, rx_data, e);
         end
         $display("pop %s data=%02h", tag, rx_data);
         rx_rd = 1'b1;
         wait_clk(1);
         rx_rd = 1'b0;
      end
      checks++;
      if (rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_empty: got rx_valid=%0b, required 0", tag, rx_valid);
      end
   endtask

   task automatic check_frame(input string tag, input int dfe, input int dpe, input int dov,
                              input int efe, input int epe, input int eov);
      checks++;
      if (dfe !== efe || dpe !== epe || dov !== eov) begin
         failures++;
         $display("FAIL %s_pulses: got fe=%0d pe=%0d ov=%0d, required fe=%0d pe=%0d ov=%0d",
                  tag, dfe, dpe, dov, efe, epe, eov);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_clk(5);
      reset = 1'b0;
      wait_clk(2);
      checks++;
      if (rx_data !== 8'h00 || rx_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got data=%02h valid=%0b busy=%0b, required 00/0/0", rx_data, rx_valid, busy);
      end
      checks++;
      if (frame_err !== 1'b0 || parity_err !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulses: got fe=%0b pe=%0b ov=%0b, required 0/0/0", frame_err, parity_err, overflow);
      end
   endtask

   task automatic test_good_frame();
      int dfe, dpe, dov, efe, epe, eov;
      model_frame(8'h1C, 1'b0, 1'b1, 1'b0, efe, epe, eov);
      run_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0, dfe, dpe, dov);
      check_frame("good_1c", dfe, dpe, dov, efe, epe, eov);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h1C || busy !== 1'b0) begin
         failures++;
         $display("FAIL good_1c_data: got valid=%0b data=%02h busy=%0b, required 1/1c/0", rx_valid, rx_data, busy);
      end
      drain("good");
   endtask

   task automatic test_errors();
      int dfe, dpe, dov, efe, epe, eov;
      model_frame(8'h1C, 1'b1, 1'b1, 1'b0, efe, epe, eov);
      run_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0, dfe, dpe, dov);
      check_frame("bad_parity", dfe, dpe, dov, efe, epe, eov);
      model_frame(8'h1C, 1'b0, 1'b0, 1'b0, efe, epe, eov);
      run_frame(8'h1C, 1'b0, 1'b0, -1, 1'b0, dfe, dpe, dov);
      check_frame("bad_stop", dfe, dpe, dov, efe, epe, eov);
      model_frame(8'h1C, 1'b1, 1'b0, 1'b0, efe, epe, eov);
      run_frame(8'h1C, 1'b1, 1'b0, -1, 1'b0, dfe, dpe, dov);
      check_frame("bad_both", dfe, dpe, dov, efe, epe, eov);
      checks++;
      if (rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL errors_valid: got rx_valid=%0b, required 0", rx_valid);
      end
   endtask

   task automatic test_timeout();
      int f0, dfe, dpe, dov, efe, epe, eov;
      f0 = fe_cnt;
      send_frame(8'h35, 1'b0, 1'b1, 5, -1, 1'b0);
      $display("partial frame: start + 4 data bits, busy=%0b", busy);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_busy_mid: got busy=%0b, required 1", busy);
      end
      wait_clk(TIMEOUT + 10);
      checks++;
      if (fe_cnt - f0 !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_abort: got frame_err pulses=%0d busy=%0b, required 1/0", fe_cnt - f0, busy);
      end
      model_frame(8'hF0, ~^8'hF0, 1'b1, 1'b0, efe, epe, eov);
      run_frame(8'hF0, ~^8'hF0, 1'b1, -1, 1'b0, dfe, dpe, dov);
      check_frame("after_timeout", dfe, dpe, dov, efe, epe, eov);
      drain("timeout");
   endtask

   task automatic test_glitch();
      int f0, dfe, dpe, dov, efe, epe, eov;
      f0 = fe_cnt;
      ps2_clk = 1'b0;
      wait_clk(3);
      ps2_clk = 1'b1;
      wait_clk(30);
      $display("idle glitch: busy=%0b", busy);
      checks++;
      if (busy !== 1'b0 || fe_cnt !== f0) begin
         failures++;
         $display("FAIL idle_glitch: got busy=%0b fe=%0d, required 0/0", busy, fe_cnt - f0);
      end
      model_frame(8'h5A, ~^8'h5A, 1'b1, 1'b0, efe, epe, eov);
      run_frame(8'h5A, ~^8'h5A, 1'b1, 4, 1'b0, dfe, dpe, dov);
      check_frame("glitch_5a", dfe, dpe, dov, efe, epe, eov);
      drain("glitch");
   endtask

   task automatic test_overflow();
      int dfe, dpe, dov, efe, epe, eov;
      logic [7:0] d;
      for (int i = 1; i <= 9; i++) begin
         d = 8'(i);
         model_frame(d, ~^d, 1'b1, 1'b0, efe, epe, eov);
         run_frame(d, ~^d, 1'b1, -1, 1'b0, dfe, dpe, dov);
         check_frame("overflow_fill", dfe, dpe, dov, efe, epe, eov);
      end
      drain("overflow");
   endtask

   task automatic test_full_pop();
      int dfe, dpe, dov, efe, epe, eov;
      logic [7:0] d;
      for (int i = 0; i < DEPTH; i++) begin
         d = 8'($urandom);
         model_frame(d, ~^d, 1'b1, 1'b0, efe, epe, eov);
         run_frame(d, ~^d, 1'b1, -1, 1'b0, dfe, dpe, dov);
      end
      model_frame(8'hAA, ~^8'hAA, 1'b1, 1'b1, efe, epe, eov);
      run_frame(8'hAA, ~^8'hAA, 1'b1, -1, 1'b1, dfe, dpe, dov);
      check_frame("full_push_pop", dfe, dpe, dov, efe, epe, eov);
      checks++;
      if (exp_q[exp_q.size()-1] !== 8'hAA) begin
         failures++;
         $display("FAIL full_model_tail: got %02h, required aa", exp_q[exp_q.size()-1]);
      end
      drain("full_pop");
   endtask

   task automatic test_random();
      int dfe, dpe, dov, efe, epe, eov, mode, npop;
      logic [7:0] d, e;
      logic par, stop;
      for (int i = 0; i < 8; i++) begin
         npop = $urandom_range(0, 2);
         for (int k = 0; k < npop && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== e) begin
               failures++;
               $display("FAIL random_pop: got valid=%0b data=%02h, required 1/%02h", rx_valid, rx_data, e);
            end
            rx_rd = 1'b1;
            wait_clk(1);
            rx_rd = 1'b0;
         end
         d = 8'($urandom);
         mode = $urandom_range(0, 3);
         par = (mode == 2) ? (^d) : ~^d;
         stop = (mode == 3) ? 1'b0 : 1'b1;
         model_frame(d, par, stop, 1'b0, efe, epe, eov);
         run_frame(d, par, stop, -1, 1'b0, dfe, dpe, dov);
         check_frame("random", dfe, dpe, dov, efe, epe, eov);
      end
      drain("random");
   endtask

   task automatic test_reset_midframe();
      int f0, dfe, dpe, dov, efe, epe, eov;
      logic [7:0] d;
      d = 8'($urandom);
      model_frame(d, ~^d, 1'b1, 1'b0, efe, epe, eov);
      run_frame(d, ~^d, 1'b1, -1, 1'b0, dfe, dpe, dov);
      f0 = fe_cnt;
      send_frame(8'h77, 1'b0, 1'b1, 4, -1, 1'b0);
      reset = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      exp_q.delete();
      wait_clk(2);
      $display("reset mid-frame: data=%02h valid=%0b busy=%0b", rx_data, rx_valid, busy);
      checks++;
      if (rx_data !== 8'h00 || rx_valid !== 1'b0 || busy !== 1'b0 ||
          frame_err !== 1'b0 || parity_err !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL midreset_outputs: got data=%02h valid=%0b busy=%0b fe=%0b pe=%0b ov=%0b, required all 0",
                  rx_data, rx_valid, busy, frame_err, parity_err, overflow);
      end
      wait_clk(TIMEOUT + 10);
      checks++;
      if (fe_cnt !== f0) begin
         failures++;
         $display("FAIL midreset_silent: got frame_err pulses=%0d, required 0", fe_cnt - f0);
      end
      d = 8'($urandom);
      model_frame(d, ~^d, 1'b1, 1'b0, efe, epe, eov);
      run_frame(d, ~^d, 1'b1, -1, 1'b0, dfe, dpe, dov);
      check_frame("after_reset", dfe, dpe, dov, efe, epe, eov);
      drain("after_reset");
   endtask

   initial begin
      wait_clk(1);
      test_reset();
      test_good_frame();
      test_errors();
      test_timeout();
      test_glitch();
      test_overflow();
      test_full_pop();
      test_random();
      test_reset_midframe();
      checks++;
      if (long_cnt !== 0) begin
         failures++;
         $display("FAIL pulse_width: got %0d multi-cycle pulses, required 0", long_cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard frame receiver for the DVK-FPGA terminal subsystem on the MiST board. It consumes the `ps2_clk`/`ps2_data` pair driven by the board's IO-controller link in the `clk_p` domain. It filters and synchronises both lines, deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and queues good scan-code bytes in a small FIFO for the keyboard controller. Framing, parity and overflow errors are reported as single-cycle pulses.

## Interface
- `FILTER_LEN`, 8: number of consecutive equal `ps2_clk` samples required to change the filtered clock level (≥2).
- `TIMEOUT`, 20000: `clk_p` cycles without a filtered falling edge mid-frame before the frame is aborted (≈200 µs at 100 MHz).
- `FIFO_DEPTH`, 8: scan-code FIFO entries; must be a power of 2.
- `clk_p` in 1: 100 MHz system clock; only clock.
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: PS/2 clock line; asynchronous.
- `ps2_data` in 1: PS/2 data line; asynchronous.
- `rx_data` out 8: FIFO head byte; valid while `rx_valid`=1.
- `rx_valid` out 1: FIFO not empty.
- `rx_rd` in 1: pop strobe; honoured only when `rx_valid`=1.
- `frame_err` out 1: 1-cycle pulse for bad stop bit or timeout.
- `parity_err` out 1: 1-cycle pulse for bad parity with a good stop bit.
- `overflow` out 1: 1-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy` out 1: deframer is not in IDLE.

## Operation
- Both inputs pass through a 2-FF synchroniser. Synchronised clock goes into a `FILTER_LEN`-bit shift register.
  - Filtered clock `fclk` becomes 1 when all bits are 1 and 0 when all bits are 0; otherwise it holds.
  - `fall` is a 1-cycle strobe on an `fclk` 1→0 transition. On that cycle the deframer samples the synchronised `ps2_data`.
- Deframer FSM states are IDLE, DATA, PARITY and STOP; it acts only on `fall`.
  - IDLE: data=0 → DATA, bit count = 0. Data=1 → stay in IDLE, no error.
  - DATA: shift data into bit 7 of the shift register, shifting right. After the 8th bit → PARITY.
  - PARITY: record `par_ok` = XOR(8 data bits, parity bit) == 1 → STOP.
  - STOP: data=1 and `par_ok` → push byte. Data=1 and not `par_ok` → `parity_err`. Data=0 → `frame_err`, which takes priority over a parity error. In all cases → IDLE.
- Timeout counter:
  - Cleared on every `fall` and while in IDLE.
  - In DATA, PARITY or STOP, reaching `TIMEOUT` forces IDLE, pulses `frame_err` and discards the partial byte.
- FIFO:
  - Show-ahead: `rx_data` presents `mem[rd_ptr]`. Pointers are log2(`FIFO_DEPTH`)+1 bits wide, with an extra wrap bit for full/empty.
  - Push when full without a pop in the same cycle → byte dropped, `overflow` pulse, FIFO contents unchanged.
  - Push and pop in the same cycle when full → both take effect, no overflow, count unchanged.
  - Push and pop in the same cycle when holding one entry → new byte is visible the next cycle and `rx_valid` stays 1.
  - `rx_rd` while empty → ignored, pointers unchanged.
- Reset:
  - FSM → IDLE. FIFO pointers → 0, so the FIFO is empty.
  - Filter register → all ones and `fclk`=1, so no spurious `fall` is seen after reset.
  - Synchronisers → 1. Timeout and bit counters → 0.
  - A frame in progress is discarded silently, with no error pulse.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overflow`=0, `busy`=0.
- Input to `fall` latency: 2 synchroniser cycles + `FILTER_LEN` cycles after the line settles low.
- Stop-bit `fall` → `rx_valid`=1 and `rx_data` updated on the next cycle, i.e. one registered push.
- Error pulses are asserted on the cycle after the qualifying `fall` or timeout and last exactly 1 cycle.
- `rx_rd` sampled high at edge N → head advances and `rx_data`/`rx_valid` reflect the new head from edge N+1.
- `busy` rises the cycle after the start-bit `fall` and falls the cycle after the stop-bit `fall` or timeout.

## Test plan
- Frame for 8'h1C: bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1, `ps2_clk` period 2000 cycles → `rx_valid`=1 and `rx_data`=8'h1C; no error pulses; `busy` returns to 0.
- Same frame with parity bit 1 → one `parity_err` pulse, `rx_valid` stays 0. Then with parity 0 and stop 0 → one `frame_err` pulse, `rx_valid` stays 0.
- Send start bit and 4 data bits, then hold `ps2_clk`=1 for `TIMEOUT`+10 cycles → one `frame_err` and `busy`=0. Then a valid 8'hF0 frame → `rx_data`=8'hF0.
- 3-cycle low glitch on `ps2_clk` in IDLE and mid-frame with `FILTER_LEN`=8 → no `fall` and no bit consumed. A later valid 8'h5A frame → 8'h5A received correctly.
- Send 9 frames 8'h01…8'h09 without `rx_rd` → one `overflow` on the 9th. Popping 8 times yields 8'h01…8'h08, then `rx_valid`=0.
- With the FIFO full, pulse `rx_rd` on the same cycle as the stop-bit push of 8'hAA → no `overflow`; after 8 pops the last byte read is 8'hAA. Assert `reset` mid-frame → all outputs at reset values, and the next full frame is received cleanly.
